// File: rtl/wb_diff_io_ctrl_pkg.sv
// Shared definitions for the Wishbone differential I/O controller: register
// byte offsets, the decoded register index and byte-lane helpers.
package wb_diff_io_pkg;

   localparam logic [31:0] REG_OUT_INV   = 32'h00;
   localparam logic [31:0] REG_IN_INV    = 32'h04;
   localparam logic [31:0] REG_OUT_EN    = 32'h08;
   localparam logic [31:0] REG_IN_STATE  = 32'h0C;
   localparam logic [31:0] REG_EDGE_STAT = 32'h10;
   localparam logic [31:0] REG_IRQ_EN    = 32'h14;
   localparam logic [31:0] REG_CNT_SEL   = 32'h18;
   localparam logic [31:0] REG_CNT_VAL   = 32'h1C;

   typedef enum logic [2:0] {
      IDX_OUT_INV   = REG_OUT_INV[4:2],
      IDX_IN_INV    = REG_IN_INV[4:2],
      IDX_OUT_EN    = REG_OUT_EN[4:2],
      IDX_IN_STATE  = REG_IN_STATE[4:2],
      IDX_EDGE_STAT = REG_EDGE_STAT[4:2],
      IDX_IRQ_EN    = REG_IRQ_EN[4:2],
      IDX_CNT_SEL   = REG_CNT_SEL[4:2],
      IDX_CNT_VAL   = REG_CNT_VAL[4:2]
   } reg_idx_e;

   // Expands the four Wishbone byte selects into a 32-bit bit mask.
   function automatic logic [31:0] byte_mask(input logic [3:0] sel);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) begin
         m[8*b +: 8] = {8{sel[b]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/wb_diff_io_ctrl_if.sv
// Wishbone classic bus bundle between the SoC master and wb_diff_io_ctrl;
// signal directions are named from the slave's point of view.
interface wb_diff_io_if;
   logic [31:0] wb_dat_i;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_adr_i;
   logic        wb_we_i;
   logic [3:0]  wb_sel_i;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_ack_o;

   modport slave (
      input  wb_dat_i, wb_adr_i, wb_we_i, wb_sel_i, wb_cyc_i, wb_stb_i,
      output wb_dat_o, wb_ack_o
   );

   modport master (
      output wb_dat_i, wb_adr_i, wb_we_i, wb_sel_i, wb_cyc_i, wb_stb_i,
      input  wb_dat_o, wb_ack_o
   );
endinterface

// File: rtl/wb_diff_io_ctrl_in_chan.sv
// One differential input channel: LVDS receiver model, synchroniser,
// polarity-aware edge detector and saturating event counter.
module diff_io_in_chan #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,      // asynchronous, active-low
   input  logic             p,
   input  logic             n,
   input  logic             inv,
   input  logic             cnt_clr,
   output logic             sync_o,
   output logic             event_o,
   output logic [CNT_W-1:0] cnt_o
);

   logic                   raw;
   logic                   raw_s;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic [CNT_W-1:0]       cnt_q, cnt_d;

   // Receiver resolves high only when P is above N; equal pins read low.
   assign raw   = p & ~n;
   assign raw_s = sync_q[SYNC_STAGES-1];

   // prev_q holds the uncorrected level, so flipping inv moves both sides of
   // the compare together and can never fabricate an edge.
   assign sync_o  = raw_s ^ inv;
   assign event_o = (raw_s ^ inv) & ~(prev_q ^ inv);

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = event_o ? CNT_W'(1) : '0;
      end else if (event_o && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // NOTE: synchroniser flops are reset too, so no stale pin level leaks
   // out of reset as a phantom edge; all state uses non-blocking updates.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
         prev_q <= raw_s;
         cnt_q  <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/wb_diff_io_ctrl.sv
// Wishbone-controlled bank of LVDS differential outputs and inputs with
// logical polarity inversion, sticky edge flags, edge counters and an IRQ.
module wb_diff_io_ctrl
   import wb_diff_io_pkg::*;
#(
   parameter int OUT_CH      = 8,
   parameter int IN_CH       = 8,
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   wb_diff_io_if.slave       wb,
   input  logic [OUT_CH-1:0] sig_out_i,
   output logic [OUT_CH-1:0] sig_out_p_o,
   output logic [OUT_CH-1:0] sig_out_n_o,
   input  logic [IN_CH-1:0]  sig_in_p_i,
   input  logic [IN_CH-1:0]  sig_in_n_i,
   output logic [IN_CH-1:0]  sig_in_o,
   output logic              irq_o
);

   localparam int SEL_W = (IN_CH > 1) ? $clog2(IN_CH) : 1;

   logic [OUT_CH-1:0] out_inv_q, out_inv_d, out_en_q, out_en_d;
   logic [IN_CH-1:0]  in_inv_q, in_inv_d, irq_en_q, irq_en_d;
   logic [IN_CH-1:0]  edge_stat_q, edge_stat_d;
   logic [SEL_W-1:0]  cnt_sel_q, cnt_sel_d;
   logic              ack_q, ack_d, irq_q, irq_d;
   logic [31:0]       dat_q, dat_d;

   logic [IN_CH-1:0]  in_corr, evt, cnt_clr;
   logic [CNT_W-1:0]  cnt [IN_CH];

   logic              req, wr, sel_valid;
   reg_idx_e          idx;
   logic [31:0]       wmask, wdat, rdata;
   logic              unused_adr;

   assign unused_adr = ^{wb.wb_adr_i[31:5], wb.wb_adr_i[1:0]};

   for (genvar i = 0; i < IN_CH; i++) begin : g_in
      diff_io_in_chan #(
         .SYNC_STAGES (SYNC_STAGES),
         .CNT_W       (CNT_W)
      ) u_chan (
         .clk     (wb_clk_i),
         .rst     (wb_rst_i),
         .p       (sig_in_p_i[i]),
         .n       (sig_in_n_i[i]),
         .inv     (in_inv_q[i]),
         .cnt_clr (cnt_clr[i]),
         .sync_o  (in_corr[i]),
         .event_o (evt[i]),
         .cnt_o   (cnt[i])
      );
   end

   // Output buffer model: P follows the driven level, N is its complement.
   for (genvar i = 0; i < OUT_CH; i++) begin : g_out
      logic drv;
      assign drv            = out_en_q[i] & (sig_out_i[i] ^ out_inv_q[i]);
      assign sig_out_p_o[i] = drv;
      assign sig_out_n_o[i] = ~drv;
   end

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      req       = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
      wr        = req & wb.wb_we_i;
      idx       = reg_idx_e'(wb.wb_adr_i[4:2]);
      wmask     = byte_mask(wb.wb_sel_i);
      wdat      = wb.wb_dat_i & wmask;
      sel_valid = int'(cnt_sel_q) < IN_CH;

      rdata = '0;
      unique case (idx)
         IDX_OUT_INV:   rdata[OUT_CH-1:0] = out_inv_q;
         IDX_IN_INV:    rdata[IN_CH-1:0]  = in_inv_q;
         IDX_OUT_EN:    rdata[OUT_CH-1:0] = out_en_q;
         IDX_IN_STATE:  rdata[IN_CH-1:0]  = in_corr;
         IDX_EDGE_STAT: rdata[IN_CH-1:0]  = edge_stat_q;
         IDX_IRQ_EN:    rdata[IN_CH-1:0]  = irq_en_q;
         IDX_CNT_SEL:   rdata[SEL_W-1:0]  = cnt_sel_q;
         IDX_CNT_VAL:   if (sel_valid) rdata[CNT_W-1:0] = cnt[cnt_sel_q];
         default:       rdata = '0;
      endcase

      out_inv_d   = out_inv_q;
      in_inv_d    = in_inv_q;
      out_en_d    = out_en_q;
      edge_stat_d = edge_stat_q;
      irq_en_d    = irq_en_q;
      cnt_sel_d   = cnt_sel_q;
      if (wr) begin
         unique case (idx)
            IDX_OUT_INV:   out_inv_d   = (out_inv_q & ~wmask[OUT_CH-1:0]) | wdat[OUT_CH-1:0];
            IDX_IN_INV:    in_inv_d    = (in_inv_q  & ~wmask[IN_CH-1:0])  | wdat[IN_CH-1:0];
            IDX_OUT_EN:    out_en_d    = (out_en_q  & ~wmask[OUT_CH-1:0]) | wdat[OUT_CH-1:0];
            IDX_EDGE_STAT: edge_stat_d = edge_stat_q & ~wdat[IN_CH-1:0];
            IDX_IRQ_EN:    irq_en_d    = (irq_en_q  & ~wmask[IN_CH-1:0])  | wdat[IN_CH-1:0];
            IDX_CNT_SEL:   cnt_sel_d   = (cnt_sel_q & ~wmask[SEL_W-1:0])  | wdat[SEL_W-1:0];
            default:       ;
         endcase
      end
      // A new event always wins over a coincident write-one-to-clear.
      edge_stat_d = edge_stat_d | evt;

      for (int i = 0; i < IN_CH; i++) begin
         cnt_clr[i] = wr && (idx == IDX_CNT_VAL) && (int'(cnt_sel_q) == i);
      end

      ack_d = req;
      dat_d = req ? rdata : '0;
      irq_d = |(edge_stat_q & irq_en_q);
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         out_inv_q   <= '0;
         in_inv_q    <= '0;
         out_en_q    <= '0;
         edge_stat_q <= '0;
         irq_en_q    <= '0;
         cnt_sel_q   <= '0;
         ack_q       <= 1'b0;
         dat_q       <= '0;
         irq_q       <= 1'b0;
      end else begin
         out_inv_q   <= out_inv_d;
         in_inv_q    <= in_inv_d;
         out_en_q    <= out_en_d;
         edge_stat_q <= edge_stat_d;
         irq_en_q    <= irq_en_d;
         cnt_sel_q   <= cnt_sel_d;
         ack_q       <= ack_d;
         dat_q       <= dat_d;
         irq_q       <= irq_d;
      end
   end

   assign wb.wb_ack_o = ack_q;
   assign wb.wb_dat_o = dat_q;
   assign sig_in_o    = in_corr;
   assign irq_o       = irq_q;

endmodule
